// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: per-stage payload structs and the stage-register
// state encoding used by pipe_stage_reg.
package pipe_pkg;

   localparam logic [1:0] ST_EMPTY = 2'd0;
   localparam logic [1:0] ST_ONE   = 2'd1;
   localparam logic [1:0] ST_FULL  = 2'd2;

   typedef enum logic [1:0] {
      EMPTY = ST_EMPTY,
      ONE   = ST_ONE,
      FULL  = ST_FULL
   } stage_state_e;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } if_id_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] rs1_val;
      logic [31:0] rs2_val;
      logic [31:0] imm;
      logic [4:0]  rd;
      logic [7:0]  ctrl;
   } id_ex_t;

   typedef struct packed {
      logic        cmp_out;
      logic [31:0] alu_out;
      logic [31:0] rs2_val;
      logic [4:0]  rd;
      logic [7:0]  ctrl;
   } ex_mem_t;

   // 1 + 32 + 32 + 32 = 97 bits
   typedef struct packed {
      logic        cmp_out;
      logic [31:0] alu_out;
      logic [31:0] rdata;
      logic [31:0] pc;
   } mem_wb_t;

   function automatic logic [1:0] state_occupancy(input stage_state_e s);
      logic [1:0] occ;
      occ = 2'd0;
      case (s)
         ONE:     occ = 2'd1;
         FULL:    occ = 2'd2;
         default: occ = 2'd0;
      endcase
      return occ;
   endfunction

endpackage

// File: rtl/pipe_stage_reg.sv
// Parametrised inter-stage register with valid/ready handshake, synchronous flush
// and an optional two-entry skid buffer that registers the ready path.
module pipe_stage_reg
   import pipe_pkg::*;
#(
   parameter int unsigned          DATA_W    = 32,
   parameter bit                   SKID      = 1'b1,
   parameter logic [DATA_W-1:0]    RESET_VAL = '0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [1:0]        occupancy
);

   stage_state_e      state;
   logic [DATA_W-1:0] main_q;
   logic              in_fire;
   logic              out_fire;

   assign out_valid = (state != EMPTY);
   assign out_data  = main_q;
   assign occupancy = state_occupancy(state);
   assign in_fire   = in_valid & in_ready;
   assign out_fire  = out_valid & out_ready;

   generate
      if (SKID) begin : g_skid
         logic [DATA_W-1:0] skid_q;

         assign in_ready = (state != FULL);

         // main_q always holds the older payload; skid_q only fills when main is stalled.
         always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
               state  <= EMPTY;
               main_q <= RESET_VAL;
               skid_q <= RESET_VAL;
            end else if (flush) begin
               state  <= EMPTY;
               main_q <= RESET_VAL;
               skid_q <= RESET_VAL;
            end else begin
               case (state)
                  EMPTY: begin
                     if (in_fire) begin
                        state  <= ONE;
                        main_q <= in_data;
                     end
                  end
                  ONE: begin
                     if (in_fire && out_fire) begin
                        main_q <= in_data;
                     end else if (in_fire) begin
                        state  <= FULL;
                        skid_q <= in_data;
                     end else if (out_fire) begin
                        state <= EMPTY;
                     end
                  end
                  FULL: begin
                     if (out_fire) begin
                        state  <= ONE;
                        main_q <= skid_q;
                     end
                  end
                  default: state <= EMPTY;
               endcase
            end
         end
      end else begin : g_direct
         // in_ready is combinational from out_ready in this mode.
         assign in_ready = !out_valid | out_ready;

         always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
               state  <= EMPTY;
               main_q <= RESET_VAL;
            end else if (flush) begin
               state  <= EMPTY;
               main_q <= RESET_VAL;
            end else if (in_fire) begin
               state  <= ONE;
               main_q <= in_data;
            end else if (out_fire) begin
               state <= EMPTY;
            end
         end
      end
   endgenerate

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
Parametrised pipeline stage register that replaces the fixed-field, load-enabled inter-stage registers between IF/ID/EX/MEM/WB. It carries an opaque DATA_W-bit payload with a valid/ready handshake and a synchronous flush for branch and exception squash. An optional two-entry skid buffer registers the ready path so that stall signals do not ripple combinationally through the whole pipeline.

Parameters:
DATA_W, 32, payload width in bits; the stage owner packs fields into one vector.
SKID, 1, 0 = single register with combinational in_ready; 1 = two-entry skid buffer with registered in_ready.
RESET_VAL, '0, DATA_W-bit value loaded into all data registers on reset and on flush.

Ports:
clk  in  1  clock; all state updates on posedge.
reset  in  1  asynchronous, active-low reset; asserted when 0.
flush  in  1  synchronous squash; empties the stage.
in_valid  in  1  upstream payload valid.
in_ready  out  1  stage can accept a payload this cycle.
in_data  in  DATA_W  upstream payload.
out_valid  out  1  out_data holds a live payload.
out_ready  in  1  downstream accepts this cycle.
out_data  out  DATA_W  payload presented downstream; always the main register.
occupancy  out  2  number of payloads held: 0, 1 or 2.

Behaviour:
- Definitions: in_fire = in_valid & in_ready. out_fire = out_valid & out_ready.
- Reset (reset = 0, asynchronous): state = EMPTY; main and skid registers = RESET_VAL; out_valid = 0; occupancy = 0. in_ready = 1 while reset is asserted and in the first cycle after release.
- Outputs for both modes: out_valid = (state != EMPTY). out_data = main register. occupancy is 0 in EMPTY, 1 in ONE, 2 in FULL. All three are registered or decoded from state only.
- SKID=1: states are EMPTY, ONE and FULL. in_ready = (state != FULL), decoded from state with no path from out_ready.
  - EMPTY: in_fire -> ONE, main <= in_data.
  - ONE: in_fire & out_fire -> ONE, main <= in_data. in_fire & !out_fire -> FULL, skid <= in_data. !in_fire & out_fire -> EMPTY. Neither -> hold.
  - FULL: in_fire cannot occur. out_fire -> ONE, main <= skid. Otherwise hold.
- SKID=0: states are EMPTY and ONE; FULL is unreachable. in_ready = !out_valid | out_ready, a combinational path from out_ready that is documented as such.
  - in_fire loads main and sets or keeps ONE.
  - out_fire without in_fire -> EMPTY.
- Latency: an accepted payload appears on out_data the next cycle (1 cycle). Throughput is one payload per cycle when out_ready is held at 1.
- Ordering: strictly FIFO. In FULL, main is always older than skid.
- Flush: highest priority after reset. On the next edge: state = EMPTY, main and skid = RESET_VAL, occupancy = 0.
  - An in_fire in the flush cycle is discarded; upstream is flushed in the same cycle.
  - An out_fire in the flush cycle still counts downstream; this stage only drops what it holds.
- Stalled data is stable: while out_valid & !out_ready and no flush, out_data and out_valid do not change.
- Reset mid-transfer: all payloads are dropped immediately (asynchronous) with no partial update.
- No X propagation: data registers only ever load in_data, skid, or RESET_VAL.

Decomposition:
- The shared package pipe_pkg holds the per-stage payload structs (if_id_t, id_ex_t, ex_mem_t, mem_wb_t; mem_wb_t = cmp_out, alu_out, rdata, pc = 97 bits). Stages instantiate the block with DATA_W = $bits(struct).
- The package also holds the state enum stage_state_e {EMPTY, ONE, FULL} and the 2-bit encoding constants.
- No sub-module is needed. One generate branch per SKID value lives inside pipe_stage_reg.

Test Plan:
1. Reset and pass-through: SKID=1, DATA_W=32, hold reset at 0 for 3 cycles, then release. Expect out_valid=0, out_data=0 and in_ready=1. Then push 0xA5A5_0001 with out_ready=1; expect out_valid=1 and out_data=0xA5A5_0001 exactly one cycle later, and occupancy=1.
2. Skid fill and stall: SKID=1, out_ready=0, push 0x11 then 0x22. Expect occupancy 1 then 2, in_ready=0 once FULL, and out_data held at 0x11 for 10 stall cycles. Raise out_ready; expect the order 0x11, 0x22, then out_valid=0.
3. Back-to-back stream: SKID=1 and SKID=0, out_ready=1, push 0..99 on consecutive cycles. Expect 100 outputs in order with no bubbles, and in_ready constant at 1.
4. Random backpressure: in_valid and out_ready each random at 50% for 10,000 cycles, both modes. Scoreboard FIFO compare shows no loss or duplication. occupancy never exceeds 1 for SKID=0 or 2 for SKID=1.
5. Flush while FULL: SKID=1, state FULL holding 0x33 and 0x44, assert flush together with in_valid carrying 0x55. Next cycle expect occupancy=0, out_valid=0 and out_data=RESET_VAL. 0x55 never appears at the output.
6. Asynchronous reset mid-operation: SKID=1 in ONE with out_ready=0, drop reset between clock edges. Expect out_valid=0 and occupancy=0 immediately, before the next posedge. After release, the first push 0x77 behaves as in scenario 1.
